// File: rtl/rename_alias_table_pkg.sv
// Shared types and sizing for the rename alias table.
// Holds the per-creg entry layout plus the slot and port widths.
package rename_alias_table_pkg;

    localparam int MACHINE_WIDTH = 2;
    localparam int RETIRE_WIDTH  = 2;
    localparam int CREG_W        = 6;
    localparam int PREG_W        = 6;
    localparam int CREG_NUM      = 1 << CREG_W;

    typedef logic [CREG_W-1:0] creg_addr_t;
    typedef logic [PREG_W-1:0] preg_addr_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t id;
    } rat_entry_t;

endpackage

// File: rtl/rename_alias_table_bypass.sv
// Intra-group dependency check for one source operand of slot SLOT.
// Only slots older than SLOT can forward; the youngest matching one wins.
module rename_alias_table_bypass
    import rename_alias_table_pkg::*;
#(
    parameter int SLOT = 0
) (
    input  logic [CREG_W-1:0]               src,
    input  logic [MACHINE_WIDTH*CREG_W-1:0] dst,
    input  logic [MACHINE_WIDTH-1:0]        we,
    input  logic [MACHINE_WIDTH*PREG_W-1:0] rob,
    output logic                            hit,
    output logic [PREG_W-1:0]               id
);

    always_comb begin
        hit = 1'b0;
        id  = '0;
        // Ascending scan so a later (younger) match overrides an older one.
        for (int j = 0; j < MACHINE_WIDTH; j++) begin
            if (j < SLOT && we[j] && dst[j*CREG_W +: CREG_W] == src) begin
                hit = 1'b1;
                id  = rob[j*PREG_W +: PREG_W];
            end
        end
    end

endmodule

// File: rtl/rename_alias_table.sv
// Rename alias table: maps each creg to its youngest in-flight ROB producer.
// Lookups are combinational from start-of-cycle state; flush, rename and retire update it.
module rename_alias_table
    import rename_alias_table_pkg::*;
(
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              flush,
    input  logic                              stall,
    input  logic [MACHINE_WIDTH-1:0]          instr_valid,
    input  logic [MACHINE_WIDTH*CREG_W-1:0]   instr_src1,
    input  logic [MACHINE_WIDTH*CREG_W-1:0]   instr_src2,
    input  logic [MACHINE_WIDTH*CREG_W-1:0]   instr_dst,
    input  logic [MACHINE_WIDTH-1:0]          instr_regwrite,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]   rob_addr_new,
    output logic [MACHINE_WIDTH-1:0]          src1_valid,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   src1_id,
    output logic [MACHINE_WIDTH-1:0]          src2_valid,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   src2_id,
    output logic [MACHINE_WIDTH-1:0]          dst_valid,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   dst_id,
    input  logic [RETIRE_WIDTH-1:0]           ret_valid,
    input  logic [RETIRE_WIDTH-1:0]           ret_regwrite,
    input  logic [RETIRE_WIDTH*CREG_W-1:0]    ret_dst,
    input  logic [RETIRE_WIDTH*PREG_W-1:0]    ret_preg
);

    rat_entry_t                 tbl [CREG_NUM];
    logic [MACHINE_WIDTH-1:0]   we;
    logic [MACHINE_WIDTH-1:0]   byp1_hit, byp2_hit;
    logic [MACHINE_WIDTH*PREG_W-1:0] byp1_id, byp2_id;

    always_comb begin
        we = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            we[i] = instr_valid[i] & instr_regwrite[i] &
                    (instr_dst[i*CREG_W +: CREG_W] != '0);
        end
    end

    for (genvar g = 0; g < MACHINE_WIDTH; g++) begin : g_slot
        rename_alias_table_bypass #(.SLOT(g)) u_byp1 (
            .src (instr_src1[g*CREG_W +: CREG_W]),
            .dst (instr_dst),
            .we  (we),
            .rob (rob_addr_new),
            .hit (byp1_hit[g]),
            .id  (byp1_id[g*PREG_W +: PREG_W])
        );
        rename_alias_table_bypass #(.SLOT(g)) u_byp2 (
            .src (instr_src2[g*CREG_W +: CREG_W]),
            .dst (instr_dst),
            .we  (we),
            .rob (rob_addr_new),
            .hit (byp2_hit[g]),
            .id  (byp2_id[g*PREG_W +: PREG_W])
        );
    end

    // A non-pending operand reports id 0 so consumers never see stale pregs.
    always_comb begin
        src1_valid = '0;
        src1_id    = '0;
        src2_valid = '0;
        src2_id    = '0;
        dst_valid  = '0;
        dst_id     = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (instr_valid[i]) begin
                if (byp1_hit[i]) begin
                    src1_valid[i]                 = 1'b1;
                    src1_id[i*PREG_W +: PREG_W]   = byp1_id[i*PREG_W +: PREG_W];
                end else if (instr_src1[i*CREG_W +: CREG_W] != '0 &&
                             tbl[instr_src1[i*CREG_W +: CREG_W]].valid) begin
                    src1_valid[i]                 = 1'b1;
                    src1_id[i*PREG_W +: PREG_W]   = tbl[instr_src1[i*CREG_W +: CREG_W]].id;
                end
                if (byp2_hit[i]) begin
                    src2_valid[i]                 = 1'b1;
                    src2_id[i*PREG_W +: PREG_W]   = byp2_id[i*PREG_W +: PREG_W];
                end else if (instr_src2[i*CREG_W +: CREG_W] != '0 &&
                             tbl[instr_src2[i*CREG_W +: CREG_W]].valid) begin
                    src2_valid[i]                 = 1'b1;
                    src2_id[i*PREG_W +: PREG_W]   = tbl[instr_src2[i*CREG_W +: CREG_W]].id;
                end
                dst_valid[i]                  = we[i];
                dst_id[i*PREG_W +: PREG_W]    = rob_addr_new[i*PREG_W +: PREG_W];
            end
        end
    end

    // Clears are evaluated against pre-edge state and issued before rename
    // writes, so a same-cycle rename to the creg overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CREG_NUM; c++) begin
                tbl[c] <= '0;
            end
        end else if (flush) begin
            for (int c = 0; c < CREG_NUM; c++) begin
                tbl[c].valid <= 1'b0;
            end
        end else begin
            for (int r = 0; r < RETIRE_WIDTH; r++) begin
                if (ret_valid[r] && ret_regwrite[r] &&
                    tbl[ret_dst[r*CREG_W +: CREG_W]].valid &&
                    tbl[ret_dst[r*CREG_W +: CREG_W]].id == ret_preg[r*PREG_W +: PREG_W]) begin
                    tbl[ret_dst[r*CREG_W +: CREG_W]].valid <= 1'b0;
                end
            end
            if (!stall) begin
                for (int i = 0; i < MACHINE_WIDTH; i++) begin
                    if (we[i]) begin
                        tbl[instr_dst[i*CREG_W +: CREG_W]] <= '{valid: 1'b1,
                                                               id: rob_addr_new[i*PREG_W +: PREG_W]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_alias_table.sv
// Self-checking bench for rename_alias_table: directed scenarios then random
// traffic, all compared against a behavioural creg->preg map.
module tb_rename_alias_table;

    logic        clk = 1'b0;
    logic        resetn, flush, stall;
    logic [1:0]  instr_valid, instr_regwrite;
    logic [11:0] instr_src1, instr_src2, instr_dst, rob_addr_new;
    logic [1:0]  src1_valid, src2_valid, dst_valid;
    logic [11:0] src1_id, src2_id, dst_id;
    logic [1:0]  ret_valid, ret_regwrite;
    logic [11:0] ret_dst, ret_preg;

    bit          m_valid [64];
    int          m_id    [64];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    rename_alias_table dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .instr_valid(instr_valid), .instr_src1(instr_src1), .instr_src2(instr_src2),
        .instr_dst(instr_dst), .instr_regwrite(instr_regwrite), .rob_addr_new(rob_addr_new),
        .src1_valid(src1_valid), .src1_id(src1_id), .src2_valid(src2_valid), .src2_id(src2_id),
        .dst_valid(dst_valid), .dst_id(dst_id),
        .ret_valid(ret_valid), .ret_regwrite(ret_regwrite), .ret_dst(ret_dst), .ret_preg(ret_preg)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int f_dst(input int i);
        return int'(instr_dst[i*6 +: 6]);
    endfunction

    function automatic int f_rob(input int i);
        return int'(rob_addr_new[i*6 +: 6]);
    endfunction

    function automatic bit f_we(input int i);
        return instr_valid[i] && instr_regwrite[i] && f_dst(i) != 0;
    endfunction

    // Expected {valid, id} as valid*64 + id for a source operand of slot i.
    function automatic int exp_src(input int i, input int src);
        if (!instr_valid[i]) return 0;
        for (int j = i - 1; j >= 0; j--)
            if (f_we(j) && f_dst(j) == src) return 64 + f_rob(j);
        if (src == 0 || !m_valid[src]) return 0;
        return 64 + m_id[src];
    endfunction

    task automatic check_outputs();
        int e1v, e1i, e2v, e2i, edv, edi, r;
        e1v = 0; e1i = 0; e2v = 0; e2i = 0; edv = 0; edi = 0;
        for (int i = 0; i < 2; i++) begin
            r = exp_src(i, int'(instr_src1[i*6 +: 6]));
            e1v |= (r / 64) << i;
            e1i |= (r % 64) << (6 * i);
            r = exp_src(i, int'(instr_src2[i*6 +: 6]));
            e2v |= (r / 64) << i;
            e2i |= (r % 64) << (6 * i);
            if (instr_valid[i]) begin
                edv |= int'(f_we(i)) << i;
                edi |= f_rob(i) << (6 * i);
            end
        end
        chk("src1_valid", int'(src1_valid), e1v);
        chk("src1_id",    int'(src1_id),    e1i);
        chk("src2_valid", int'(src2_valid), e2v);
        chk("src2_id",    int'(src2_id),    e2i);
        chk("dst_valid",  int'(dst_valid),  edv);
        chk("dst_id",     int'(dst_id),     edi);
    endtask

    task automatic model_update();
        bit nv [64];
        int ni [64];
        int d, p;
        if (!resetn) return;
        if (flush) begin
            for (int c = 0; c < 64; c++) m_valid[c] = 0;
            return;
        end
        nv = m_valid;
        ni = m_id;
        for (int r = 0; r < 2; r++) begin
            d = int'(ret_dst[r*6 +: 6]);
            p = int'(ret_preg[r*6 +: 6]);
            if (ret_valid[r] && ret_regwrite[r] && m_valid[d] && m_id[d] == p) nv[d] = 0;
        end
        if (!stall)
            for (int i = 0; i < 2; i++)
                if (f_we(i)) begin
                    nv[f_dst(i)] = 1;
                    ni[f_dst(i)] = f_rob(i);
                end
        m_valid = nv;
        m_id    = ni;
    endtask

    task automatic clear_inputs();
        flush = 0; stall = 0;
        instr_valid = '0; instr_regwrite = '0;
        instr_src1 = '0; instr_src2 = '0; instr_dst = '0; rob_addr_new = '0;
        ret_valid = '0; ret_regwrite = '0; ret_dst = '0; ret_preg = '0;
    endtask

    task automatic slot(input int i, input int s1, input int s2, input int d,
                        input bit rw, input int rob);
        instr_valid[i]         = 1'b1;
        instr_regwrite[i]      = rw;
        instr_src1[i*6 +: 6]   = 6'(s1);
        instr_src2[i*6 +: 6]   = 6'(s2);
        instr_dst[i*6 +: 6]    = 6'(d);
        rob_addr_new[i*6 +: 6] = 6'(rob);
    endtask

    task automatic ret(input int r, input int d, input int p);
        ret_valid[r]       = 1'b1;
        ret_regwrite[r]    = 1'b1;
        ret_dst[r*6 +: 6]  = 6'(d);
        ret_preg[r*6 +: 6] = 6'(p);
    endtask

    // Called at a negedge with inputs driven: compare, clock, advance model.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        int d;
        for (int c = 0; c < 64; c++) begin m_valid[c] = 0; m_id[c] = 0; end
        resetn = 0;
        clear_inputs();
        @(negedge clk);
        slot(0, 5, 0, 0, 0, 0);
        #1 chk("reset_src1_5_valid", int'(src1_valid[0]), 0);
        @(negedge clk);
        resetn = 1;
        clear_inputs();
        @(negedge clk);

        slot(0, 5, 0, 5, 1, 12);
        step();
        slot(0, 5, 0, 0, 0, 0);
        #1 chk("lookup5_after_rename", {25'd0, src1_valid[0], src1_id[5:0]}, 64 + 12);
        step();

        slot(0, 3, 3, 3, 1, 7);
        slot(1, 0, 3, 0, 0, 0);
        #1 chk("bypass_slot1_src2", {25'd0, src2_valid[1], src2_id[11:6]}, 64 + 7);
        chk("slot0_no_self_bypass", int'(src1_valid[0]), 0);
        step();

        slot(0, 0, 0, 4, 1, 8);
        slot(1, 0, 0, 4, 1, 9);
        step();
        ret(0, 4, 8);
        slot(0, 4, 0, 0, 0, 0);
        step();
        slot(0, 4, 0, 0, 0, 0);
        #1 chk("stale_retire_keeps", {25'd0, src1_valid[0], src1_id[5:0]}, 64 + 9);
        step();
        ret(1, 4, 9);
        step();
        slot(0, 4, 0, 0, 0, 0);
        #1 chk("retire_clears", int'(src1_valid[0]), 0);
        step();

        slot(0, 0, 0, 6, 1, 15);
        step();
        slot(0, 0, 0, 6, 1, 20);
        ret(0, 6, 15);
        step();
        slot(1, 6, 0, 0, 0, 0);
        #1 chk("rename_beats_clear", {25'd0, src1_valid[1], src1_id[11:6]}, 64 + 20);
        step();

        for (int k = 1; k <= 31; k += 2) begin
            slot(0, 0, 0, k, 1, k);
            if (k < 31) slot(1, 0, 0, k + 1, 1, k + 1);
            step();
        end
        flush = 1;
        slot(0, 0, 0, 2, 1, 40);
        step();
        slot(0, 1, 2, 0, 0, 0);
        slot(1, 31, 17, 0, 0, 0);
        #1 chk("flush_clears_all", int'({src1_valid, src2_valid}), 0);
        step();

        stall = 1;
        slot(0, 10, 0, 10, 1, 30);
        step();
        slot(0, 10, 0, 0, 1, 33);
        #1 chk("stall_no_write", int'(src1_valid[0]), 0);
        chk("dst0_not_valid", int'(dst_valid[0]), 0);
        step();
        slot(1, 0, 0, 0, 0, 0);
        step();

        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 31) == 0);
            stall = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 3) != 0)
                    slot(i, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 63));
            for (int r = 0; r < 2; r++)
                if ($urandom_range(0, 1) != 0) begin
                    d = $urandom_range(0, 7);
                    ret(r, d, ($urandom_range(0, 1) != 0) ? m_id[d] : $urandom_range(0, 63));
                    ret_regwrite[r] = 1'($urandom_range(0, 3) != 0);
                end
            step();
        end

        slot(0, 0, 0, 9, 1, 33);
        step();
        resetn = 0;
        slot(0, 9, 0, 0, 0, 0);
        #1 chk("async_reset_clears", int'(src1_valid[0]), 0);
        for (int c = 0; c < 64; c++) begin m_valid[c] = 0; m_id[c] = 0; end
        @(negedge clk);
        resetn = 1;
        clear_inputs();
        slot(0, 9, 9, 0, 0, 0);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
